fwd_hazard_ctrl: RTL

Sequencer for the EX-stage operand multiplexers of the 5-stage pipeline. It shadows destination-register information for the EX and MEM stages and produces registered 2-bit selects for the two 32-bit 3:1 ALU-operand muxes: register file, MEM/WB result or EX/MEM result. It also detects load-use hazards, asserts a one-cycle stall, injects a bubble, and counts stalls for performance debug.

---
 rtl/fwd_hazard_ctrl_pkg.sv | 20 ++
 rtl/fwd_hazard_ctrl_fwd_select.sv | 30 +++
 rtl/fwd_hazard_ctrl.sv | 96 +++++++++
 3 files changed

// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared pipeline definitions for the EX-stage operand forwarding and
// load-use hazard logic.
package fwd_hazard_ctrl_pkg;

    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    // Destination info tracked for one in-flight pipeline stage
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] dest;
        logic              wr;
    } shadow_t;

endpackage

// File: rtl/fwd_hazard_ctrl_fwd_select.sv
// Operand select for one source register: the newest in-flight producer of
// that register wins; register 0 is never forwarded.
module fwd_select
    import fwd_hazard_ctrl_pkg::*;
(
    input  logic [REG_AW-1:0] src,
    input  logic              uses,
    input  shadow_t           ex_sh,
    input  shadow_t           mem_sh,
    output fwd_sel_e          sel
);

    logic ex_hit;
    logic mem_hit;

    assign ex_hit  = ex_sh.valid  && ex_sh.wr  && (ex_sh.dest  == src);
    assign mem_hit = mem_sh.valid && mem_sh.wr && (mem_sh.dest == src);

    always_comb begin
        sel = FWD_RF;
        if (uses && (src != '0)) begin
            if (ex_hit) begin
                sel = FWD_MEM;
            end else if (mem_hit) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// EX-stage forwarding select sequencer with load-use stall detection,
// bubble injection and a saturating stall counter.
module fwd_hazard_ctrl
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              flush,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_count
);

    shadow_t  ex_q;
    logic     ex_ld_q;
    shadow_t  mem_q;
    fwd_sel_e a_next;
    fwd_sel_e b_next;
    fwd_sel_e a_sel_q;
    fwd_sel_e b_sel_q;
    logic     bubble;
    logic     src_hits_load;

    fwd_select u_sel_rs (
        .src    (id_rs),
        .uses   (id_uses_rs),
        .ex_sh  (ex_q),
        .mem_sh (mem_q),
        .sel    (a_next)
    );

    fwd_select u_sel_rt (
        .src    (id_rt),
        .uses   (id_uses_rt),
        .ex_sh  (ex_q),
        .mem_sh (mem_q),
        .sel    (b_next)
    );

    assign src_hits_load = (id_uses_rs && (id_rs == ex_q.dest)) ||
                           (id_uses_rt && (id_rt == ex_q.dest));

    // A flush overrides the stall: the killed instruction need not wait for the load
    assign stall = id_valid && !flush && ex_q.valid && ex_ld_q && ex_q.wr &&
                   (ex_q.dest != '0) && src_hits_load;

    assign bubble = stall || flush || !id_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q    <= '0;
            ex_ld_q <= 1'b0;
            mem_q   <= '0;
            a_sel_q <= FWD_RF;
            b_sel_q <= FWD_RF;
        end else begin
            mem_q <= ex_q;
            if (bubble) begin
                ex_q    <= '0;
                ex_ld_q <= 1'b0;
                a_sel_q <= FWD_RF;
                b_sel_q <= FWD_RF;
            end else begin
                ex_q.valid <= 1'b1;
                ex_q.dest  <= id_dest;
                ex_q.wr    <= id_reg_write;
                ex_ld_q    <= id_mem_read;
                a_sel_q    <= a_next;
                b_sel_q    <= b_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

    assign fwd_a_sel = a_sel_q;
    assign fwd_b_sel = b_sel_q;

endmodule
